// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller
//   Issues one decoded floating-point coprocessor instruction at a time to the
//   FP datapath. Each operation is timed either by a fixed per-op latency or by
//   the divider's done signal. The controller then produces the register-file
//   write, compare-flag write or store-request strobe.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   in_valid/in_ready       instruction handshake from the integer pipeline
//   in_opcode/rs/rt/rd      decoded instruction fields
//   in_ldata                load data (lw)
//   dp_start                one-cycle start pulse to the datapath
//   dp_op/rs/rt/rd          latched op select and register addresses
//   dp_done                 divider result valid
//   rf_we/waddr/wsel/wdata  register-file write port control
//   flag_we                 compare-flag write strobe
//   st_valid/st_raddr       store request and register to read
//   st_ready                memory accepted the store
//   busy                    an instruction is in flight
//   illegal_op              one-cycle pulse on an undefined opcode
//   div_timeout             sticky divider-timeout flag
module fpu_issue_controller #(
  parameter int ADD_LAT     = 2,
  parameter int MUL_LAT     = 3,
  parameter int MISC_LAT    = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_ldata,
  output logic        dp_start,
  output logic [3:0]  dp_op,
  output logic [4:0]  dp_rs,
  output logic [4:0]  dp_rt,
  output logic [4:0]  dp_rd,
  input  logic        dp_done,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        rf_wsel,
  output logic [31:0] rf_wdata,
  output logic        flag_we,
  output logic        st_valid,
  output logic [4:0]  st_raddr,
  input  logic        st_ready,
  output logic        busy,
  output logic        illegal_op,
  output logic        div_timeout
);

  localparam int CW = 16;
  localparam int TW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] ADD_LD   = CW'(ADD_LAT - 1);
  localparam logic [CW-1:0] MUL_LD   = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] MISC_LD  = CW'(MISC_LAT - 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, EXEC, WAIT_DIV, WB, STORE} state_t;

  // Low nibble of the opcode once the 6'b11xxxx prefix is stripped.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
    OP_CMP = 4'd4, OP_REV = 4'd5, OP_RND = 4'd6, OP_LW  = 4'd7,
    OP_SW  = 4'd8
  } op_t;

  state_t        state;
  op_t           cur_op;
  op_t           dec_op;
  logic          dec_legal;
  logic          accept;
  logic [CW-1:0] lat_load;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;

  // Gating with reset keeps the pipeline from handing over an instruction
  // that the reset would silently drop.
  assign in_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign dp_op    = cur_op;
  assign rf_waddr = dp_rd;

  always_comb begin
    dec_legal = (in_opcode[5:4] == 2'b11) && (in_opcode[3:0] <= 4'd8);
    dec_op    = op_t'(in_opcode[3:0]);
    lat_load  = MISC_LD;
    case (dec_op)
      OP_ADD, OP_SUB: lat_load = ADD_LD;
      OP_MUL:         lat_load = MUL_LD;
      default:        lat_load = MISC_LD;
    endcase
  end

  // Strobes are raised on the transition into their state so that they are
  // registered and coincide exactly with the WB / first EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_op      <= OP_ADD;
      dp_rs       <= '0;
      dp_rt       <= '0;
      dp_rd       <= '0;
      rf_wdata    <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      dp_start    <= 1'b0;
      rf_we       <= 1'b0;
      rf_wsel     <= 1'b0;
      flag_we     <= 1'b0;
      st_valid    <= 1'b0;
      st_raddr    <= '0;
      illegal_op  <= 1'b0;
      div_timeout <= 1'b0;
    end else begin
      dp_start   <= 1'b0;
      rf_we      <= 1'b0;
      rf_wsel    <= 1'b0;
      flag_we    <= 1'b0;
      illegal_op <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (!dec_legal) begin
              illegal_op <= 1'b1;
            end else begin
              cur_op   <= dec_op;
              dp_rs    <= in_rs;
              dp_rt    <= in_rt;
              dp_rd    <= in_rd;
              rf_wdata <= in_ldata;
              case (dec_op)
                OP_LW: begin
                  state   <= WB;
                  rf_we   <= 1'b1;
                  rf_wsel <= 1'b1;
                end
                OP_SW: begin
                  state    <= STORE;
                  st_valid <= 1'b1;
                  st_raddr <= in_rt;
                end
                OP_DIV: begin
                  state    <= WAIT_DIV;
                  dp_start <= 1'b1;
                  tcnt     <= '0;
                end
                default: begin
                  state    <= EXEC;
                  dp_start <= 1'b1;
                  cnt      <= lat_load;
                end
              endcase
            end
          end
        end

        EXEC: begin
          if (cnt == '0) begin
            state <= WB;
            if (cur_op == OP_CMP) flag_we <= 1'b1;
            else                  rf_we   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        WAIT_DIV: begin
          if (dp_done) begin
            state <= WB;
            rf_we <= 1'b1;
          end else if (tcnt == DIV_LAST) begin
            state       <= IDLE;
            div_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        WB: state <= IDLE;

        STORE: begin
          if (st_ready) begin
            state    <= IDLE;
            st_valid <= 1'b0;
            st_raddr <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_controller.sv
module tb_fpu_issue_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_ldata;
  logic        dp_start;
  logic [3:0]  dp_op;
  logic [4:0]  dp_rs, dp_rt, dp_rd;
  logic        dp_done;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        rf_wsel;
  logic [31:0] rf_wdata;
  logic        flag_we;
  logic        st_valid;
  logic [4:0]  st_raddr;
  logic        st_ready;
  logic        busy;
  logic        illegal_op;
  logic        div_timeout;

  fpu_issue_controller #(
    .ADD_LAT    (2),
    .MUL_LAT    (3),
    .MISC_LAT   (1),
    .DIV_TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_ldata   (in_ldata),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .dp_rs      (dp_rs),
    .dp_rt      (dp_rt),
    .dp_rd      (dp_rd),
    .dp_done    (dp_done),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wsel    (rf_wsel),
    .rf_wdata   (rf_wdata),
    .flag_we    (flag_we),
    .st_valid   (st_valid),
    .st_raddr   (st_raddr),
    .st_ready   (st_ready),
    .busy       (busy),
    .illegal_op (illegal_op),
    .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  // Event kinds seen by the monitor
  localparam int K_WB    = 0;
  localparam int K_FLAG  = 1;
  localparam int K_STORE = 2;
  localparam int K_ILL   = 3;
  localparam int K_TOUT  = 4;
  localparam int K_BAD   = 9;

  typedef struct {
    int          kind;
    int          addr;
    int          wsel;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  logic prev_to = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int kind, input int addr, input int wsel,
                             input logic [31:0] data, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.wsel = wsel; e.data = data; e.cyc = c;
    return e;
  endfunction

  task automatic compare_ev(input ev_t a);
    ev_t e;
    bit  ok;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0d at cyc %0d, required none",
               a.kind, a.addr, a.cyc);
    end else begin
      e  = exp_q.pop_front();
      ok = (a.kind == e.kind) && (a.cyc == e.cyc);
      if (e.kind == K_WB)
        ok = ok && (a.addr == e.addr) && (a.wsel == e.wsel) &&
             ((e.wsel == 0) || (a.data === e.data));
      if (e.kind == K_STORE) ok = ok && (a.addr == e.addr);
      if (!ok) begin
        n_fail++;
        $display("FAIL event: got kind %0d addr %0d wsel %0d data %0h cyc %0d, required kind %0d addr %0d wsel %0d data %0h cyc %0d",
                 a.kind, a.addr, a.wsel, a.data, a.cyc, e.kind, e.addr, e.wsel, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT strobes into events and checks them against the queue.
  always @(negedge clk) begin
    if (rf_we || flag_we)
      compare_ev(mk((rf_we && flag_we) ? K_BAD : (rf_we ? K_WB : K_FLAG),
                    int'(rf_waddr), int'(rf_wsel), rf_wdata, cyc));
    if (st_valid && st_ready)
      compare_ev(mk(K_STORE, int'(st_raddr), 0, '0, cyc));
    if (illegal_op)
      compare_ev(mk(K_ILL, 0, 0, '0, cyc));
    if (div_timeout && !prev_to)
      compare_ev(mk(K_TOUT, 0, 0, '0, cyc));
    prev_to <= div_timeout;
  end

  task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] ld, output int e);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("issue_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_ldata  = ld;
    @(posedge clk);
    #1;
    e        = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int e, r;
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_ldata = '0; dp_done = 1'b0; st_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {dp_start, rf_we, flag_we, st_valid, illegal_op, div_timeout}, 0);
    chk("rst_dp_op", dp_op, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // add rs=1 rt=2 rd=3: WB in cycle 3, ready in cycle 4
    issue(6'b110000, 5'd1, 5'd2, 5'd3, 32'h0, e);
    exp_q.push_back(mk(K_WB, 3, 0, '0, e + 2));
    @(negedge clk);
    chk("add_c1_start", dp_start, 1);
    chk("add_c1_op", dp_op, 0);
    chk("add_c1_regs", {dp_rs, dp_rt, dp_rd}, {5'd1, 5'd2, 5'd3});
    chk("add_c1_ready", in_ready, 0);
    chk("add_c1_busy", busy, 1);
    @(negedge clk);
    chk("add_c2_start", dp_start, 0);
    chk("add_c2_ready", in_ready, 0);
    @(negedge clk);
    chk("add_c3_ready", in_ready, 0);
    @(negedge clk);
    chk("add_c4_ready", in_ready, 1);
    chk("add_c4_we", rf_we, 0);

    // lw rd=7: WB in cycle 1, no dp_start
    issue(6'b110111, 5'd0, 5'd0, 5'd7, 32'h3F800000, e);
    exp_q.push_back(mk(K_WB, 7, 1, 32'h3F800000, e));
    @(negedge clk);
    chk("lw_c1_start", dp_start, 0);
    @(negedge clk);
    chk("lw_c2_ready", in_ready, 1);
    chk("lw_c2_start", dp_start, 0);

    // dp_done while idle must be ignored
    @(posedge clk); #1 dp_done = 1'b1;
    @(posedge clk); #1 dp_done = 1'b0;
    @(negedge clk);
    chk("stray_done_busy", busy, 0);

    // div with dp_done in cycle 5: WB in cycle 6
    issue(6'b110011, 5'd4, 5'd5, 5'd6, 32'h0, e);
    exp_q.push_back(mk(K_WB, 6, 0, '0, e + 5));
    @(negedge clk);
    chk("div_c1_start", dp_start, 1);
    chk("div_c1_op", dp_op, 3);
    repeat (3) @(negedge clk);
    chk("div_c4_busy", busy, 1);
    @(posedge clk); #1 dp_done = 1'b1;
    @(posedge clk); #1 dp_done = 1'b0;
    wait_idle();

    // div with no dp_done: timeout after 64 wait cycles
    issue(6'b110011, 5'd1, 5'd1, 5'd10, 32'h0, e);
    exp_q.push_back(mk(K_TOUT, 0, 0, '0, e + 64));
    repeat (64) @(negedge clk);
    chk("tout_c64_flag", div_timeout, 0);
    chk("tout_c64_busy", busy, 1);
    @(negedge clk);
    chk("tout_c65_flag", div_timeout, 1);
    chk("tout_c65_ready", in_ready, 1);

    // add afterwards completes normally; timeout stays sticky
    issue(6'b110000, 5'd2, 5'd2, 5'd11, 32'h0, e);
    exp_q.push_back(mk(K_WB, 11, 0, '0, e + 2));
    wait_idle();
    chk("tout_sticky", div_timeout, 1);

    // sw rt=9 with st_ready low for 3 cycles
    issue(6'b111000, 5'd0, 5'd9, 5'd0, 32'h0, e);
    exp_q.push_back(mk(K_STORE, 9, 0, '0, e + 3));
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) st_ready = 1'b1;
      @(negedge clk);
      chk("sw_valid", st_valid, 1);
      chk("sw_raddr", st_raddr, 9);
      chk("sw_no_we", rf_we, 0);
      @(posedge clk); #1;
    end
    st_ready = 1'b0;
    @(negedge clk);
    chk("sw_cleared", st_valid, 0);
    chk("sw_ready", in_ready, 1);

    // illegal opcode: one pulse, nothing else moves
    issue(6'b111111, 5'd3, 5'd3, 5'd3, 32'h0, e);
    exp_q.push_back(mk(K_ILL, 0, 0, '0, e));
    @(negedge clk);
    chk("ill_busy", busy, 0);
    chk("ill_ready", in_ready, 1);
    chk("ill_start", dp_start, 0);
    chk("ill_dp_op_kept", dp_op, 8);
    @(negedge clk);
    chk("ill_pulse_end", illegal_op, 0);

    // cmp: flag_we in cycle 2 (MISC_LAT=1), no rf_we
    issue(6'b110100, 5'd2, 5'd3, 5'd4, 32'h0, e);
    exp_q.push_back(mk(K_FLAG, 0, 0, '0, e + 1));
    wait_idle();

    // rev to register 0: ordinary write
    issue(6'b110101, 5'd1, 5'd0, 5'd0, 32'h0, e);
    exp_q.push_back(mk(K_WB, 0, 0, '0, e + 1));
    wait_idle();

    // reset during mul EXEC: no write, outputs cleared, immediate re-accept
    issue(6'b110010, 5'd1, 5'd2, 5'd5, 32'h0, e);
    @(negedge clk);
    chk("mul_c1_start", dp_start, 1);
    chk("mul_c1_op", dp_op, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mul_rst_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    r = cyc;
    @(negedge clk);
    chk("mul_rst_busy", busy, 0);
    chk("mul_rst_strobes", {dp_start, rf_we, flag_we, st_valid, illegal_op, div_timeout}, 0);
    chk("mul_rst_dp", {dp_op, dp_rs, dp_rt, dp_rd}, 0);
    chk("mul_rst_ready", in_ready, 1);
    issue(6'b110001, 5'd1, 5'd1, 5'd12, 32'h0, e);
    chk("rst_reaccept_edge", e, r + 1);
    exp_q.push_back(mk(K_WB, 12, 0, '0, e + 2));
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fpu_issue_controller.md
Name: fpu_issue_controller

Overview:
- Sequences the floating-point coprocessor datapath one instruction at a time.
- Accepts decoded coprocessor instructions from the integer pipeline over a valid/ready handshake, then drives the datapath start, operand and destination addresses.
- Times each operation by a fixed per-op latency, or waits for the divider's done signal.
- Generates the register-file write, compare-flag write and store-request strobes; raises busy and error status back to the pipeline.

Parameters:
- ADD_LAT, 2, cycles from dp_start to result valid for add/sub (>=1)
- MUL_LAT, 3, cycles for mul (>=1)
- MISC_LAT, 1, cycles for cmp/rev/rnd (>=1)
- DIV_TIMEOUT, 64, max cycles waiting for dp_done before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept
- in_opcode  in  6  coprocessor opcode
- in_rs  in  5  source register 1
- in_rt  in  5  source register 2
- in_rd  in  5  destination register
- in_ldata  in  32  load data, used for lw
- dp_start  out  1  one-cycle start pulse to the datapath
- dp_op  out  4  op select: opcode minus 6'b110000 (0=add … 6=rnd)
- dp_rs, dp_rt, dp_rd  out  5 each  latched operand and destination addresses
- dp_done  in  1  divider result valid (div only)
- rf_we  out  1  register-file write strobe
- rf_waddr  out  5  write address
- rf_wsel  out  1  0 = datapath result, 1 = rf_wdata
- rf_wdata  out  32  latched load data
- flag_we  out  1  compare-flag write strobe (cmp)
- st_valid  out  1  store request
- st_raddr  out  5  register to read for the store
- st_ready  in  1  memory accepted the store
- busy  out  1  state != IDLE
- illegal_op  out  1  one-cycle pulse on a bad opcode
- div_timeout  out  1  sticky until reset

Behaviour:
- Reset values: all outputs 0 except in_ready (0 during the reset cycle, 1 in the first cycle after it). State goes to IDLE, counters clear, sticky flags clear.
- Reset mid-operation: the in-flight op is discarded and no write occurs.
- States: IDLE, EXEC, WAIT_DIV, WB, STORE.
- in_ready = (state==IDLE). A transfer happens when in_valid && in_ready.
- On accept, the controller latches opcode, rs/rt/rd and ldata.
- Opcode map:
  - 110000 add, 110001 sub, 110010 mul, 110011 div
  - 110100 cmp, 110101 rev, 110110 rnd
  - 110111 lw, 111000 sw
- Any other opcode: illegal_op pulses in the next cycle; state stays IDLE; no other output changes.
- add/sub/mul/cmp/rev/rnd, IDLE -> EXEC:
  - dp_start = 1 for the first EXEC cycle only.
  - The counter loads LAT-1 and decrements each cycle; at 0, EXEC -> WB.
- div, IDLE -> WAIT_DIV:
  - dp_start pulses in the first cycle; the timeout counter starts at 0.
  - dp_done=1 -> WB.
  - After DIV_TIMEOUT cycles with no dp_done: div_timeout=1 (sticky), return to IDLE, no write.
  - dp_done outside WAIT_DIV is ignored.
- lw, IDLE -> WB directly: rf_wsel=1, rf_wdata=latched ldata.
- WB lasts exactly 1 cycle, then IDLE:
  - rf_we=1 and rf_waddr=dp_rd for every op except cmp.
  - cmp asserts flag_we=1 instead, with rf_we=0.
  - rf_wsel=0 except for lw.
- sw, IDLE -> STORE:
  - st_valid=1 and st_raddr=latched rt, held until st_ready is sampled high.
  - Then IDLE; no register write.
- Timing, accept at edge 0:
  - add: dp_start in cycle 1, WB in cycle 1+ADD_LAT, in_ready high in cycle 2+ADD_LAT.
  - lw: WB in cycle 1, ready in cycle 2.
- dp_rs/dp_rt/dp_rd/dp_op hold their latched values from accept until the next accept. They are stable throughout EXEC, WAIT_DIV and WB.
- Register 0 is an ordinary writable register.
- Only one op is in flight; there is no queue.

Test Plan:
- Reset, then add (110000, rs=1, rt=2, rd=3) with ADD_LAT=2:
  - dp_start in cycle 1, dp_op=0.
  - rf_we=1, rf_waddr=3, rf_wsel=0 in cycle 3 only.
  - in_ready 0 in cycles 1–3, 1 in cycle 4.
- lw (110111, rd=7, in_ldata=32'h3F800000):
  - rf_we=1, rf_wsel=1, rf_waddr=7, rf_wdata=3F800000 in cycle 1.
  - dp_start never asserted.
- div with dp_done at cycle 5: WB in cycle 6. A second div with dp_done never asserted: div_timeout=1 after 64 wait cycles, no rf_we, in_ready returns. A later add completes normally and div_timeout stays 1.
- sw (111000, rt=9) with st_ready low for 3 cycles: st_valid=1 and st_raddr=9 held for 4 cycles, then cleared; rf_we stays 0.
- Illegal opcode 111111: illegal_op pulses for 1 cycle, busy stays 0, no strobes. cmp (110100): flag_we=1 at cycle 1+MISC_LAT with rf_we=0.
- reset asserted during mul EXEC: no rf_we, all outputs 0 next cycle. A new instruction is accepted right after reset deasserts.
